// File: rtl/systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_sequencer
// Brief    : Buffers two SIZE x SIZE operand matrices row by row, then streams
//            them skewed into an output-stationary systolic array. After the
//            drain it captures the array results and holds them until the
//            consumer accepts them.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_sequencer #(
  parameter int SIZE         = 8,
  parameter int I_BITS       = 8,
  parameter int O_BITS       = (I_BITS*2)+$clog2(SIZE),
  parameter int DRAIN_CYCLES = SIZE
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_load_valid,
  output logic                          o_load_ready,
  input  logic [SIZE*I_BITS-1:0]        i_load_a_row,
  input  logic [SIZE*I_BITS-1:0]        i_load_b_row,
  output logic                          o_arr_reset,
  output logic [SIZE*I_BITS-1:0]        o_arr_a,
  output logic [SIZE*I_BITS-1:0]        o_arr_b,
  input  logic [SIZE*SIZE*O_BITS-1:0]   i_arr_c,
  output logic                          o_res_valid,
  input  logic                          i_res_ready,
  output logic [SIZE*SIZE*O_BITS-1:0]   o_res_c,
  output logic                          o_busy
);

  localparam int C_ROW_W   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int C_CNT_W   = $clog2(2*SIZE + DRAIN_CYCLES + 1);
  localparam int C_LANE_W  = SIZE*I_BITS;
  localparam int C_RES_W   = SIZE*SIZE*O_BITS;
  localparam logic [C_ROW_W-1:0] C_ROW_LAST   = C_ROW_W'(SIZE-1);
  localparam logic [C_CNT_W-1:0] C_FEED_LAST  = C_CNT_W'(2*SIZE-2);
  localparam logic [C_CNT_W-1:0] C_DRAIN_LAST =
    C_CNT_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES-1) : 0);

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [C_ROW_W-1:0]   row_q, row_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_RES_W-1:0]   res_c_q, res_c_d;
  logic [C_LANE_W-1:0]  a_buf_q [SIZE];
  logic [C_LANE_W-1:0]  a_buf_d [SIZE];
  logic [C_LANE_W-1:0]  b_buf_q [SIZE];
  logic [C_LANE_W-1:0]  b_buf_d [SIZE];
  logic                 buf_we;

  // Control registers; reset aborts any operation and returns to LOAD.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_LOAD;
      row_q   <= '0;
      cnt_q   <= '0;
      res_c_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      res_c_q <= res_c_d;
    end
  end

  // Operand buffers hold data across a reset; every operation reloads all rows.
  always_ff @(posedge i_clock) begin
    a_buf_q <= a_buf_d;
    b_buf_q <= b_buf_d;
  end

  // Next-state logic: row counter in LOAD, shared cycle counter in FEED/DRAIN.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    res_c_d = res_c_q;
    buf_we  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (i_load_valid) begin
          buf_we = 1'b1;
          if (row_q == C_ROW_LAST) begin
            state_d = ST_CLEAR;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        cnt_d   = '0;
      end
      ST_FEED: begin
        if (cnt_q == C_FEED_LAST) begin
          cnt_d = '0;
          if (DRAIN_CYCLES == 0) begin
            // No drain requested: results are taken straight after the feed.
            state_d = ST_OUT;
            res_c_d = i_arr_c;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == C_DRAIN_LAST) begin
          state_d = ST_OUT;
          cnt_d   = '0;
          res_c_d = i_arr_c;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (i_res_ready) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Buffer write path: only accepted LOAD beats update the addressed row.
  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (buf_we) begin
      a_buf_d[row_q] = i_load_a_row;
      b_buf_d[row_q] = i_load_b_row;
    end
  end

  // Skewed operand lanes: lane q carries element index k = t - q while in range.
  always_comb begin
    int                 diff;
    logic [C_ROW_W-1:0] k;
    logic [C_ROW_W-1:0] lane;
    o_arr_a = '0;
    o_arr_b = '0;
    diff    = 0;
    k       = '0;
    lane    = '0;
    if (state_q == ST_FEED) begin
      for (int q = 0; q < SIZE; q++) begin
        diff = int'(cnt_q) - q;
        k    = C_ROW_W'(diff);
        lane = C_ROW_W'(q);
        if ((diff >= 0) && (diff < SIZE)) begin
          o_arr_a[q*I_BITS +: I_BITS] = a_buf_q[lane][k*I_BITS +: I_BITS];
          o_arr_b[q*I_BITS +: I_BITS] = b_buf_q[k][q*I_BITS +: I_BITS];
        end
      end
    end
  end

  // Status outputs decode the registered state; reset also clears the array.
  assign o_load_ready = (state_q == ST_LOAD);
  assign o_busy       = (state_q == ST_CLEAR) || (state_q == ST_FEED) ||
                        (state_q == ST_DRAIN);
  assign o_res_valid  = (state_q == ST_OUT);
  assign o_res_c      = res_c_q;
  assign o_arr_reset  = i_reset || (state_q == ST_CLEAR);

endmodule
`default_nettype wire
